fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipelined MIPS core. It sits directly upstream of the IF/ID latch. It owns the PC and drives instruction-memory requests (imemREN/imemaddr). It presents fetched words plus next PC (PC+4) to IF/ID, and applies branch/jump redirects from later stages, hazard stalls and HALT.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset
WORD_W, 32, width of PC, addresses and instruction words

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset, synchronous, active-low; sampled only on rising CLK edge
ihit  in  1  instruction memory/cache returned valid word for imemaddr this cycle
imemload  in  WORD_W  instruction word, valid when ihit=1
stall  in  1  hazard unit: downstream (ID/EX) paused, hold PC
redirect_en  in  1  taken branch/jump/JR resolved downstream, one-cycle pulse
redirect_pc  in  WORD_W  redirect target
halt  in  1  HALT decoded on a correct path
imemREN  out  1  instruction read enable
imemaddr  out  WORD_W  instruction address (= PC)
fetch_valid  out  1  to IF/ID ihit input: capture this cycle
fetch_npc  out  WORD_W  PC+4 of word being delivered
fetch_imemload  out  WORD_W  instruction word delivered (= imemload)
flush  out  1  to IF/ID dopause: squash latch contents
fetch_count  out  32  count of instructions delivered (fetch_valid cycles)

Behaviour:
- States: RUN, PEND (redirect waiting for in-flight miss), HALTED. Registers: pc, pend_pc, state, fetch_count.
- Reset (nRST=0 at rising edge): pc=PC_INIT, pend_pc=0, state=RUN, fetch_count=0. Reset wins over every other input, in any state including PEND/HALTED.
- imemaddr = pc at all times. imemREN = 1 in RUN and PEND, 0 in HALTED and while nRST=0.
- Memory contract: imemaddr held stable while imemREN=1 and ihit=0. pc never changes during an outstanding miss.
- fetch_npc = pc + 4, modulo 2^WORD_W; wraps 0xFFFFFFFC -> 0x00000000. fetch_imemload = imemload.
- fetch_valid = (state==RUN) & ihit & ~stall & ~redirect_en & ~halt. Combinational.
- flush = redirect_en | halt. Combinational. Squashes wrong-path word in IF/ID.
- Redirect targets are word-aligned by forcing bits [1:0] to 00.
- RUN, priority order:
  1. redirect_en & ihit -> pc=redirect_pc, stay RUN.
  2. redirect_en & ~ihit -> pend_pc=redirect_pc, go PEND, pc unchanged.
  3. halt -> HALTED, pc unchanged.
  4. ihit & ~stall -> pc=pc+4.
  5. Otherwise hold pc.
  - Redirect beats stall and halt; stall and halt are wrong-path.
  - Stall with ihit drops the word; the same pc is re-read later.
- PEND:
  - fetch_valid=0 and the returned word is discarded.
  - redirect_en again -> pend_pc overwritten (newest wins).
  - ihit -> pc=pend_pc (or new redirect_pc if redirect_en same cycle), go RUN.
  - stall and halt ignored in PEND.
- HALTED: pc frozen, no requests, fetch_valid=0. Only reset exits. redirect_en ignored.
- fetch_count increments by 1 on each fetch_valid cycle and wraps at 2^32.
- Latency: redirect on a hit cycle -> new address on imemaddr the next cycle. First request is issued in the cycle after reset deasserts.

Test Plan:
1. Reset then ihit every cycle, no stall -> imemaddr 0,4,8,C on consecutive cycles. fetch_npc 4,8,C,10. fetch_count=4 after 4 hits.
2. pc=0x10, ihit=1, stall=1 for 3 cycles, then stall=0 -> imemaddr holds 0x10 and fetch_valid=0 for 3 cycles. Then fetch_valid=1, fetch_npc=0x14, pc=0x14.
3. pc=0x20 missing (ihit=0); redirect_en pulse with redirect_pc=0x103; ihit 4 cycles later -> imemaddr stays 0x20 until ihit, fetch_valid=0, flush=1 in redirect cycle only. Next cycle imemaddr=0x100.
4. In PEND, second redirect to 0x200 before ihit -> after ihit imemaddr=0x200, not the first target.
5. halt=1 at pc=0x40 -> next cycle imemREN=0, imemaddr=0x40 frozen. Redirect/ihit ignored. nRST=0 -> imemaddr=PC_INIT, imemREN resumes.
6. pc=0xFFFFFFFC ihit -> fetch_npc=0x00000000, next imemaddr=0. Reset asserted mid-PEND -> state RUN, pc=PC_INIT, pending target discarded.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and feeds IF/ID.
// Handles branch/jump redirects (deferred while a miss is in flight), hazard stalls and HALT.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic              fetch_valid,
    output logic [WORD_W-1:0] fetch_npc,
    output logic [WORD_W-1:0] fetch_imemload,
    output logic              flush,
    output logic [31:0]       fetch_count
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [WORD_W-1:0]  pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    logic [WORD_W-1:0]  redirect_aligned;
    logic [WORD_W-1:0]  pc_plus4;

    assign redirect_aligned = {redirect_pc[WORD_W-1:2], 2'b00};
    assign pc_plus4         = pc_q + WORD_W'(4);

    assign imemaddr       = pc_q;
    assign imemREN        = nRST && (state_q != HALTED);
    assign fetch_npc      = pc_plus4;
    assign fetch_imemload = imemload;
    assign fetch_valid    = (state_q == RUN) && ihit && !stall && !redirect_en && !halt;
    assign flush          = redirect_en || halt;
    assign fetch_count    = fetch_count_q;

    // Next-state: pc only moves on a returned word so the address stays stable across a miss
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        fetch_count_d = fetch_count_q;
        if (fetch_valid) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
        unique case (state_q)
            RUN: begin
                if (redirect_en && ihit) begin
                    pc_d = redirect_aligned;
                end else if (redirect_en) begin
                    pend_pc_d = redirect_aligned;
                    state_d   = PEND;
                end else if (halt) begin
                    state_d = HALTED;
                end else if (ihit && !stall) begin
                    pc_d = pc_plus4;
                end
            end
            PEND: begin
                // Newest redirect wins, even when it lands on the completing cycle
                if (redirect_en) begin
                    pend_pc_d = redirect_aligned;
                end
                if (ihit) begin
                    pc_d    = redirect_en ? redirect_aligned : pend_pc_q;
                    state_d = RUN;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= RUN;
            pc_q          <= WORD_W'(PC_INIT);
            pend_pc_q     <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, stall, deferred redirect,
// redirect overwrite, halt, PC wrap and reset during a pending redirect.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        fetch_valid;
    logic [31:0] fetch_npc;
    logic [31:0] fetch_imemload;
    logic        flush;
    logic [31:0] fetch_count;

    int tests  = 0;
    int errors = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000), .WORD_W(32)) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .imemload       (imemload),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .fetch_valid    (fetch_valid),
        .fetch_npc      (fetch_npc),
        .fetch_imemload (fetch_imemload),
        .flush          (flush),
        .fetch_count    (fetch_count)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0; idle_inputs(); imemload = 32'hDEAD_BEEF;
        tick(); tick();
        tests++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", imemaddr, 32'h0); end
        tests++; if (imemREN !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", imemREN); end
        tests++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        nRST = 1'b1; #1;
        tests++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_ren_release got %b exp 1", imemREN); end
    endtask

    task automatic test_sequential();
        ihit = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imemload = 32'h1000_0000 + 32'(i); #1;
            tests++; if (imemaddr !== 32'(4*i)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imemaddr, 32'(4*i)); end
            tests++; if (fetch_npc !== 32'(4*i+4)) begin errors++; $display("FAIL seq_npc[%0d] got %h exp %h", i, fetch_npc, 32'(4*i+4)); end
            tests++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, fetch_valid); end
            tests++; if (fetch_imemload !== 32'h1000_0000 + 32'(i)) begin errors++; $display("FAIL seq_word[%0d] got %h", i, fetch_imemload); end
            tick();
        end
        ihit = 1'b0; #1;
        tests++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_stall();
        ihit = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (imemaddr !== 32'h10) begin errors++; $display("FAIL stall_addr[%0d] got %h exp 10", i, imemaddr); end
            tests++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 0", i, fetch_valid); end
            tick();
        end
        stall = 1'b0; #1;
        tests++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid got %b exp 1", fetch_valid); end
        tests++; if (fetch_npc !== 32'h14) begin errors++; $display("FAIL unstall_npc got %h exp 14", fetch_npc); end
        tick(); ihit = 1'b0; #1;
        tests++; if (imemaddr !== 32'h14) begin errors++; $display("FAIL unstall_addr got %h exp 14", imemaddr); end
        tests++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL stall_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_redirect_miss();
        // Redirect on a hit cycle: new address visible next cycle
        ihit = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h20; #1;
        tests++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL rdhit_flush got flush=%b valid=%b exp 1/0", flush, fetch_valid); end
        tick();
        tests++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL rdhit_addr got %h exp 20", imemaddr); end
        // Redirect while 0x20 misses
        ihit = 1'b0; redirect_pc = 32'h103; #1;
        tests++; if (flush !== 1'b1) begin errors++; $display("FAIL rdmiss_flush got %b exp 1", flush); end
        tick(); redirect_en = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (imemaddr !== 32'h20 || flush !== 1'b0) begin errors++; $display("FAIL pend_hold[%0d] got addr=%h flush=%b exp 20/0", i, imemaddr, flush); end
            tick();
        end
        ihit = 1'b1; #1;
        tests++; if (fetch_valid !== 1'b0 || imemaddr !== 32'h20) begin errors++; $display("FAIL pend_hit got valid=%b addr=%h exp 0/20", fetch_valid, imemaddr); end
        tick(); ihit = 1'b0; #1;
        tests++; if (imemaddr !== 32'h100) begin errors++; $display("FAIL pend_target got %h exp 100", imemaddr); end
        tests++; if (fetch_count !== 32'd5) begin errors++; $display("FAIL pend_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_pend_overwrite();
        ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h300; tick();
        redirect_pc = 32'h200; tick();
        redirect_en = 1'b0; stall = 1'b1; halt = 1'b1; tick();
        #1;
        tests++; if (imemaddr !== 32'h100 || imemREN !== 1'b1) begin errors++; $display("FAIL ovr_hold got addr=%h ren=%b exp 100/1", imemaddr, imemREN); end
        halt = 1'b0; stall = 1'b0; ihit = 1'b1; tick();
        ihit = 1'b0; #1;
        tests++; if (imemaddr !== 32'h200) begin errors++; $display("FAIL ovr_target got %h exp 200", imemaddr); end
    endtask

    task automatic test_halt();
        logic [31:0] cnt;
        ihit = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h40; tick();
        redirect_en = 1'b0; halt = 1'b1; #1;
        tests++; if (flush !== 1'b1 || fetch_valid !== 1'b0) begin errors++; $display("FAIL halt_flush got flush=%b valid=%b exp 1/0", flush, fetch_valid); end
        cnt = fetch_count;
        tick(); halt = 1'b0; #1;
        tests++; if (imemREN !== 1'b0 || imemaddr !== 32'h40) begin errors++; $display("FAIL halted got ren=%b addr=%h exp 0/40", imemREN, imemaddr); end
        redirect_en = 1'b1; redirect_pc = 32'h500; tick();
        redirect_en = 1'b0; #1;
        tests++; if (imemaddr !== 32'h40 || fetch_valid !== 1'b0 || imemREN !== 1'b0) begin errors++; $display("FAIL halted_ign got addr=%h valid=%b ren=%b exp 40/0/0", imemaddr, fetch_valid, imemREN); end
        tests++; if (fetch_count !== cnt) begin errors++; $display("FAIL halted_count got %0d exp %0d", fetch_count, cnt); end
        nRST = 1'b0; tick();
        tests++; if (imemaddr !== 32'h0 || imemREN !== 1'b0) begin errors++; $display("FAIL halt_reset got addr=%h ren=%b exp 0/0", imemaddr, imemREN); end
        nRST = 1'b1; #1;
        tests++; if (imemREN !== 1'b1 || fetch_valid !== 1'b1) begin errors++; $display("FAIL halt_resume got ren=%b valid=%b exp 1/1", imemREN, fetch_valid); end
    endtask

    task automatic test_wrap_and_pend_reset();
        ihit = 1'b1; redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFE; tick();
        redirect_en = 1'b0; #1;
        tests++; if (imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h exp FFFFFFFC", imemaddr); end
        tests++; if (fetch_npc !== 32'h0 || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_npc got npc=%h valid=%b exp 0/1", fetch_npc, fetch_valid); end
        tick();
        tests++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", imemaddr); end
        // Enter PEND at 0x0 towards 0x600, then reset
        ihit = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h600; tick();
        redirect_en = 1'b0; nRST = 1'b0; tick();
        nRST = 1'b1; ihit = 1'b1; #1;
        tests++; if (fetch_valid !== 1'b1 || imemaddr !== 32'h0) begin errors++; $display("FAIL pendrst_run got valid=%b addr=%h exp 1/0", fetch_valid, imemaddr); end
        tests++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL pendrst_count got %0d exp 0", fetch_count); end
        tick(); ihit = 1'b0; #1;
        tests++; if (imemaddr !== 32'h4) begin errors++; $display("FAIL pendrst_next got %h exp 4", imemaddr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_miss();
        test_pend_overwrite();
        test_halt();
        test_wrap_and_pend_reset();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
